mem_wait_bridge: RTL
====================

MEM_WAIT_BRIDGE -- requirements
Module: mem_wait_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum BUSY cycles before a bus-error abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) forces the reset state immediately, independent of clk.
REQ-004 MemRead  input  1  processor requests a word read (instruction fetch or load).
REQ-005 MemWrite  input  1  processor requests a word write (store).
REQ-006 Adr  input  32  processor byte address.
REQ-007 WriteData  input  32  processor store data.
REQ-008 ReadData  output  32  registered read data returned to the processor.
REQ-009 Stall  output  1  freezes the processor's multi-cycle controller and datapath registers while high.
REQ-010 BusErr  output  1  one-cycle pulse marking an aborted (timed-out) access.
REQ-011 mem_req  output  1  memory request, held until accepted.
REQ-012 mem_we  output  1  write qualifier for mem_req.
REQ-013 mem_addr  output  30  word address, equal to the latched Adr[31:2].
REQ-014 mem_wdata  output  32  latched store data.
REQ-015 mem_ready  input  1  memory completes the current access in this cycle.
REQ-016 mem_rdata  input  32  read data, valid only when mem_ready=1 and mem_we=0.

Function
REQ-017 FSM states: IDLE, BUSY, DONE; encoding is free.
REQ-018 IDLE with MemRead|MemWrite=1: latch Adr[31:2], WriteData, and we=MemWrite; clear the cycle counter; go to BUSY.
REQ-019 Simultaneous MemRead and MemWrite: treated as a write (MemWrite priority); no read data is captured.
REQ-020 Stall is combinational: 1 in BUSY; 1 in IDLE when MemRead|MemWrite=1; 0 in DONE and in IDLE with no request.
REQ-021 BUSY: mem_req=1, and mem_we, mem_addr and mem_wdata hold their latched values, stable until exit.
REQ-022 BUSY with mem_ready=1: on a read, capture mem_rdata into ReadData; go to DONE.
REQ-023 BUSY with mem_ready=0: the 8-bit counter increments; when the counter equals TIMEOUT-1 and mem_ready=0, ReadData is set to 32'h0, BusErr is asserted for the DONE cycle, and the FSM goes to DONE.
REQ-024 mem_ready=1 in the same cycle the timeout is reached: completes normally, with no BusErr.
REQ-025 Minimum latency: request seen in IDLE at cycle N, mem_ready=1 at N+1, DONE at N+2 with Stall=0 and ReadData valid.
REQ-026 DONE: mem_req=0 and Stall=0, so the processor advances on this edge. The FSM returns to IDLE unconditionally; request inputs sampled in DONE are ignored.
REQ-027 mem_req is 0 in IDLE and DONE; mem_ready outside BUSY is ignored.
REQ-028 ReadData holds its last captured value until the next completed read or timeout; writes never change it.
REQ-029 Back-to-back accesses: a request present in the IDLE cycle following DONE starts immediately, with no dead cycle beyond DONE.

Reset
REQ-030 reset=0: FSM=IDLE, counter=0, ReadData=32'h0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 reset asserted mid-access (BUSY): the access is abandoned, mem_req drops asynchronously, and no ReadData update occurs.
REQ-032 After reset is released, the first rising edge evaluates IDLE normally.

Verification
REQ-033 Read, zero wait: MemRead=1, Adr=32'h0000_0104, mem_ready=1 in the first BUSY cycle with mem_rdata=32'hE3A0_1005 -> mem_addr=30'h41, Stall high for 2 cycles, ReadData=32'hE3A0_1005 in DONE.
REQ-034 Write, 3 wait states: MemWrite=1, Adr=32'h40, WriteData=32'hCAFE_0001; mem_ready high on the 4th BUSY cycle -> mem_we=1, mem_wdata stable for 4 cycles, ReadData unchanged.
REQ-035 Timeout: TIMEOUT=16, mem_ready never asserted -> 16 BUSY cycles, then DONE with BusErr=1 for one cycle and ReadData=0.
REQ-036 Simultaneous request: MemRead=MemWrite=1 -> mem_we=1, and ReadData is not updated.
REQ-037 Reset mid-access: reset=0 in the 2nd BUSY cycle -> mem_req=0 and Stall=0 before the next edge; after release, a new read completes normally.
REQ-038 Back-to-back: fetch then load, each with mem_ready=1 on the first BUSY cycle -> pattern IDLE,BUSY,DONE,IDLE,BUSY,DONE, with both ReadData values correct.

Source files
------------

// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge: couples a multi-cycle processor's single-cycle memory
// strobes to a memory port that may insert wait states. The processor is
// stalled while an access is outstanding. A bounded wait turns into a
// bus-error abort with one-cycle BusErr and zeroed read data.
module mem_wait_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value still allowed to wait; the access aborts from here.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  cnt_r;
  logic        we_r;
  logic [29:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        buserr_r;

  logic        req_in_s;
  logic        timeout_s;
  logic        stall_s;
  logic        mem_req_s;

  // Byte-lane bits are meaningless for word accesses.
  logic        unused_adr_s;
  assign unused_adr_s = ^Adr[1:0];

  assign req_in_s  = MemRead | MemWrite;
  assign timeout_s = (state_r == BUSY) && !mem_ready && (cnt_r == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: DONE always returns to IDLE so a pending request starts
  // in the following cycle without any extra dead cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_in_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready || timeout_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: Stall is raised in the request cycle itself so the
  // processor never advances past an unaccepted access; reset forces it low.
  always_comb begin
    stall_s   = 1'b0;
    mem_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s   = req_in_s;
        mem_req_s = 1'b0;
      end
      BUSY: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
      end
      DONE: begin
        stall_s   = 1'b0;
        mem_req_s = 1'b0;
      end
      default: begin
        stall_s   = 1'b0;
        mem_req_s = 1'b0;
      end
    endcase
    if (!reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // Access latches, wait counter, read data capture and bus-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= 8'd0;
      we_r     <= 1'b0;
      addr_r   <= 30'd0;
      wdata_r  <= 32'd0;
      rdata_r  <= 32'd0;
      buserr_r <= 1'b0;
    end else begin
      buserr_r <= timeout_s;
      case (state_r)
        IDLE: begin
          if (req_in_s) begin
            addr_r  <= Adr[31:2];
            wdata_r <= WriteData;
            we_r    <= MemWrite;
            cnt_r   <= 8'd0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!we_r) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
          end else if (timeout_s) begin
            rdata_r <= 32'h0000_0000;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        DONE:    cnt_r <= cnt_r;
        default: cnt_r <= 8'd0;
      endcase
    end
  end

  assign ReadData  = rdata_r;
  assign Stall     = stall_s;
  assign BusErr    = buserr_r;
  assign mem_req   = mem_req_s;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule
